// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller: state encoding,
// default score width and serve direction constants.
package pong_pkg;

   localparam int SCORE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SERVE = 2'b01,
      ST_PLAY  = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as
// the physics tick.
module pong_tick_gen #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == CNT_MAX)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: IDLE/SERVE/PLAY/OVER, physics tick gating,
// score keeping and ball re-centre requests.
module pong_game_ctrl #(
   parameter int TICK_DIV    = 1_000_000,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 9,
   parameter int SCORE_W     = pong_pkg::SCORE_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic               physics_en,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic [1:0]         game_state,
   output logic               winner
);

   import pong_pkg::*;

   localparam int SRV_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;
   localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);

   state_t             state, state_d;
   logic               tick;
   logic               start_q, start_edge;
   logic [SRV_W-1:0]   serve_cnt, serve_cnt_d;
   logic [SCORE_W-1:0] score_l_d, score_r_d, score_l_inc, score_r_inc;
   logic               winner_d, serve_dir_d, ball_reset_d, physics_en_d;

   pong_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign start_edge  = start_btn & ~start_q;
   assign score_l_inc = score_l + 1'b1;
   assign score_r_inc = score_r + 1'b1;

   always_comb begin
      state_d      = state;
      serve_cnt_d  = serve_cnt;
      score_l_d    = score_l;
      score_r_d    = score_r;
      winner_d     = winner;
      serve_dir_d  = serve_dir;
      ball_reset_d = 1'b0;
      physics_en_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_edge) begin
               state_d      = ST_SERVE;
               serve_cnt_d  = '0;
               score_l_d    = '0;
               score_r_d    = '0;
               winner_d     = 1'b0;
               serve_dir_d  = DIR_RIGHT;
               ball_reset_d = 1'b1;
            end
         end
         ST_SERVE: begin
            if (tick) begin
               if (serve_cnt == SRV_LAST)
                  state_d = ST_PLAY;
               else
                  serve_cnt_d = serve_cnt + 1'b1;
            end
         end
         ST_PLAY: begin
            // A miss suppresses the tick so physics_en never coincides with ball_reset
            if (miss_l && miss_r) begin
               state_d      = ST_SERVE;
               serve_cnt_d  = '0;
               ball_reset_d = 1'b1;
            end else if (miss_l) begin
               score_r_d = score_r_inc;
               if (score_r_inc == WIN_S) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d      = ST_SERVE;
                  serve_cnt_d  = '0;
                  serve_dir_d  = DIR_LEFT;
                  ball_reset_d = 1'b1;
               end
            end else if (miss_r) begin
               score_l_d = score_l_inc;
               if (score_l_inc == WIN_S) begin
                  state_d  = ST_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d      = ST_SERVE;
                  serve_cnt_d  = '0;
                  serve_dir_d  = DIR_RIGHT;
                  ball_reset_d = 1'b1;
               end
            end else begin
               physics_en_d = tick;
            end
         end
         ST_OVER: begin
            if (start_edge)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // start_q resets high so a button held through reset is not seen as a press
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         start_q    <= 1'b1;
         serve_cnt  <= '0;
         score_l    <= '0;
         score_r    <= '0;
         winner     <= 1'b0;
         serve_dir  <= 1'b0;
         ball_reset <= 1'b0;
         physics_en <= 1'b0;
      end else begin
         state      <= state_d;
         start_q    <= start_btn;
         serve_cnt  <= serve_cnt_d;
         score_l    <= score_l_d;
         score_r    <= score_r_d;
         winner     <= winner_d;
         serve_dir  <= serve_dir_d;
         ball_reset <= ball_reset_d;
         physics_en <= physics_en_d;
      end
   end

   assign game_state = state;

endmodule
